serv_bus_sched: RTL and testbench
=================================

Name: serv_bus_sched

Overview:
- Registered scheduler that shares one Wishbone-classic memory port between the SERV instruction bus and data bus.
- Sits between the core's state/fetch logic, which drives the ibus/dbus cycle requests, and the external memory interconnect.
- Grants one requester at a time and holds the grant until ack or abort.
- Supervises each transaction with a watchdog that flags a hung bus.

Parameters:
- DBUS_PRIO, 1, when both requests arrive in the same IDLE cycle: 1 = dbus wins, 0 = ibus wins.
- TMO_W, 8, width of the watchdog counter.
- TMO_CYCLES, 200, cycles in a grant state without ack before a timeout is declared; must be less than 2^TMO_W.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ibus_adr  in  32  instruction fetch address
- i_ibus_cyc  in  1  instruction fetch request
- o_ibus_ack  out  1  fetch ack to core
- o_ibus_rdt  out  32  fetch read data
- i_dbus_adr  in  32  data address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte selects
- i_dbus_we  in  1  write enable
- i_dbus_cyc  in  1  data request
- o_dbus_ack  out  1  data ack to core
- o_dbus_rdt  out  32  data read data
- o_wb_adr  out  32  shared port address
- o_wb_dat  out  32  shared port write data
- o_wb_sel  out  4  shared port byte selects
- o_wb_we  out  1  shared port write enable
- o_wb_cyc  out  1  shared port cycle/strobe
- i_wb_rdt  in  32  shared port read data
- i_wb_ack  in  1  shared port ack
- o_tmo  out  1  sticky timeout flag
- o_tmo_src  out  1  requester that timed out: 0 = ibus, 1 = dbus
- i_tmo_clr  in  1  synchronous clear of o_tmo

Behaviour:
- States: IDLE, GNT_I, GNT_D, TURN. State, o_wb_* and the watchdog are registered; clock is i_clk.
- Reset (i_rst_n = 0, asynchronous): state = IDLE; o_wb_cyc = 0; o_wb_we = 0; o_wb_adr, o_wb_dat, o_wb_sel = 0; counter = 0; o_tmo = 0; o_tmo_src = 0.
- IDLE:
  - Only ibus requesting -> GNT_I. Only dbus requesting -> GNT_D.
  - Both requesting -> winner set by DBUS_PRIO.
  - On entry to a grant state, the granted requester's adr/dat/sel/we are captured into o_wb_*. For ibus, o_wb_we = 0, o_wb_sel = 4'hF and o_wb_dat = 0.
  - o_wb_cyc rises on the clock edge that enters the grant state, i.e. one cycle after the request is first seen.
- GNT_x:
  - o_wb_cyc = 1 and o_wb_* stay stable.
  - When i_wb_ack = 1, the granted requester's ack is o_x_ack = i_wb_ack, combinationally in the same cycle, and o_x_rdt = i_wb_rdt.
  - The non-granted ack is always 0.
  - The rdt outputs carry i_wb_rdt unconditionally.
  - On ack: next state TURN; o_wb_cyc = 0 and the counter clears.
- Abort: if the granted requester deasserts cyc while in GNT_x with no ack that cycle, go to TURN and drop o_wb_cyc. A late i_wb_ack in TURN or IDLE is ignored and never forwarded.
- Ack and requester-drop in the same cycle: the ack wins and is forwarded.
- TURN: exactly one cycle with o_wb_cyc = 0, then IDLE. Back-to-back transactions therefore start at most every 3 cycles after ack, since IDLE arbitrates on the following cycle.
- Fairness: in IDLE, the requester that was not served in the previous transaction wins a tie, overriding DBUS_PRIO. DBUS_PRIO decides ties only for the first transaction after reset.
- Watchdog:
  - The counter increments every cycle in a grant state without ack.
  - When the counter reaches TMO_CYCLES-1 with no ack: set o_tmo = 1, set o_tmo_src = the granted requester, force TURN, drop o_wb_cyc, no ack forwarded.
  - The requester then retries or hangs under core control.
  - The counter saturates and never wraps.
- i_tmo_clr clears o_tmo. If a new timeout occurs in the same cycle, the set wins.
- Captured o_wb_* fields hold their last values in IDLE and TURN; only o_wb_cyc qualifies them.

Test Plan:
- Single ibus fetch: i_ibus_cyc = 1, adr = 0x0000_0100, ack on the 3rd grant cycle -> o_wb_cyc rises 1 cycle after the request; o_wb_adr = 0x100, we = 0, sel = F; o_ibus_ack pulses with i_wb_ack and o_ibus_rdt = 0xDEAD_BEEF; then 1 TURN cycle.
- Simultaneous request after reset, DBUS_PRIO = 1: dbus write adr = 0x2000, dat = 0x1234_5678, sel = 0x3 is granted first. After its ack, the next IDLE grants ibus even though dbus re-requests. The order D, I, D repeats under continuous contention.
- Abort: dbus granted, i_dbus_cyc dropped on grant cycle 2 -> o_wb_cyc = 0 next cycle. An i_wb_ack arriving 1 cycle later -> o_dbus_ack and o_ibus_ack both stay 0.
- Timeout with TMO_CYCLES = 4, ibus granted, no ack -> o_tmo = 1 and o_tmo_src = 0 after 4 grant cycles; o_wb_cyc drops; i_tmo_clr pulse returns o_tmo to 0.
- Async reset mid-transaction: deassert i_rst_n during GNT_D between clock edges -> o_wb_cyc = 0 immediately, state IDLE, o_tmo = 0.
- Ack and requester-drop in the same cycle: o_ibus_ack = 1 is forwarded and the state goes to TURN.

Source files
------------

// File: rtl/serv_bus_sched.sv
// Arbitrates SERV ibus/dbus onto one Wishbone-classic port. The grant is registered, so o_wb_cyc follows a request by 1 cycle.
// Acks pass straight through from i_wb_ack. Aborts, acks and watchdog timeouts each add one idle TURN cycle.
module serv_bus_sched #(
    parameter bit DBUS_PRIO  = 1'b1,
    parameter int TMO_W      = 8,
    parameter int TMO_CYCLES = 200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic        o_ibus_ack,
    output logic [31:0] o_ibus_rdt,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic        o_dbus_ack,
    output logic [31:0] o_dbus_rdt,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_tmo,
    output logic        o_tmo_src,
    input  logic        i_tmo_clr
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] cnt;
    logic             served_any;
    logic             last_d;
    logic             in_gnt;
    logic             nxt_gnt;
    logic             gnt_cyc;
    logic             ack_fwd;
    logic             tmo_hit;
    logic             pick_d;

    assign in_gnt  = (state == GNT_I) || (state == GNT_D);
    assign nxt_gnt = (state_nxt == GNT_I) || (state_nxt == GNT_D);
    assign gnt_cyc = (state == GNT_I) ? i_ibus_cyc : i_dbus_cyc;
    assign ack_fwd = in_gnt && i_wb_ack;
    assign tmo_hit = in_gnt && !i_wb_ack && (cnt == TMO_LAST);

    // On a tie the requester not served last time wins; DBUS_PRIO only breaks the very first tie.
    always_comb begin
        pick_d = i_dbus_cyc;
        if (i_ibus_cyc && i_dbus_cyc)
            pick_d = served_any ? ~last_d : DBUS_PRIO;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_ibus_cyc || i_dbus_cyc)
                    state_nxt = pick_d ? GNT_D : GNT_I;
            end
            GNT_I, GNT_D: begin
                if (ack_fwd || tmo_hit || !gnt_cyc)
                    state_nxt = TURN;
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ibus_ack = (state == GNT_I) && i_wb_ack;
    assign o_dbus_ack = (state == GNT_D) && i_wb_ack;
    assign o_ibus_rdt = i_wb_rdt;
    assign o_dbus_rdt = i_wb_rdt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_wb_sel   <= '0;
            cnt        <= '0;
            o_tmo      <= 1'b0;
            o_tmo_src  <= 1'b0;
            served_any <= 1'b0;
            last_d     <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_wb_cyc <= nxt_gnt;

            if (state == IDLE && state_nxt == GNT_D) begin
                o_wb_adr   <= i_dbus_adr;
                o_wb_dat   <= i_dbus_dat;
                o_wb_sel   <= i_dbus_sel;
                o_wb_we    <= i_dbus_we;
                served_any <= 1'b1;
                last_d     <= 1'b1;
            end else if (state == IDLE && state_nxt == GNT_I) begin
                o_wb_adr   <= i_ibus_adr;
                o_wb_dat   <= '0;
                o_wb_sel   <= 4'hF;
                o_wb_we    <= 1'b0;
                served_any <= 1'b1;
                last_d     <= 1'b0;
            end

            // Counts cycles spent in a grant; saturates rather than wrapping.
            if (in_gnt && nxt_gnt) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            if (tmo_hit) begin
                o_tmo     <= 1'b1;
                o_tmo_src <= (state == GNT_D);
            end else if (i_tmo_clr) begin
                o_tmo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serv_bus_sched.sv
// Directed self-checking bench for serv_bus_sched (watchdog shortened to 4 cycles).
module tb_serv_bus_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus_adr = '0;
    logic        ibus_cyc = 1'b0;
    logic        ibus_ack;
    logic [31:0] ibus_rdt;
    logic [31:0] dbus_adr = '0;
    logic [31:0] dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we = 1'b0;
    logic        dbus_cyc = 1'b0;
    logic        dbus_ack;
    logic [31:0] dbus_rdt;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt = '0;
    logic        wb_ack = 1'b0;
    logic        tmo;
    logic        tmo_src;
    logic        tmo_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serv_bus_sched #(.DBUS_PRIO(1'b1), .TMO_W(8), .TMO_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_ack(ibus_ack), .o_ibus_rdt(ibus_rdt),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(dbus_cyc), .o_dbus_ack(dbus_ack), .o_dbus_rdt(dbus_rdt),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
        .o_tmo(tmo), .o_tmo_src(tmo_src), .i_tmo_clr(tmo_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ibus_cyc = 1'b1; dbus_cyc = 1'b1; wb_ack = 1'b1;
        tick;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL reset_cyc: got %b exp 0", wb_cyc); end
        n_cmp++; if (wb_adr !== 32'h0) begin n_err++; $display("FAIL reset_adr: got %h exp 0", wb_adr); end
        n_cmp++; if ({wb_we, wb_sel, wb_dat} !== 37'h0) begin n_err++; $display("FAIL reset_fields: we %b sel %h dat %h exp 0", wb_we, wb_sel, wb_dat); end
        n_cmp++; if ({tmo, tmo_src} !== 2'b00) begin n_err++; $display("FAIL reset_tmo: got %b%b exp 00", tmo, tmo_src); end
        n_cmp++; if ({ibus_ack, dbus_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b%b exp 00", ibus_ack, dbus_ack); end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; wb_ack = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL idle_cyc: got %b exp 0", wb_cyc); end
    endtask

    task automatic test_contention;
        ibus_adr = 32'h300; ibus_cyc = 1'b1;
        dbus_adr = 32'h2000; dbus_dat = 32'h1234_5678; dbus_sel = 4'h3; dbus_we = 1'b1; dbus_cyc = 1'b1;
        #1;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL cont_req_cyc: got %b exp 0", wb_cyc); end
        tick;
        n_cmp++; if ({wb_cyc, wb_adr, wb_dat, wb_sel, wb_we} !== {1'b1, 32'h2000, 32'h1234_5678, 4'h3, 1'b1})
            begin n_err++; $display("FAIL cont_first_d: cyc %b adr %h dat %h sel %h we %b exp 1 2000 12345678 3 1", wb_cyc, wb_adr, wb_dat, wb_sel, wb_we); end
        wb_ack = 1'b1; wb_rdt = 32'hAAAA_0001; #1;
        n_cmp++; if ({dbus_ack, ibus_ack} !== 2'b10) begin n_err++; $display("FAIL cont_d_ack: got d%b i%b exp d1 i0", dbus_ack, ibus_ack); end
        n_cmp++; if (dbus_rdt !== 32'hAAAA_0001) begin n_err++; $display("FAIL cont_d_rdt: got %h exp aaaa0001", dbus_rdt); end
        tick; wb_ack = 1'b0;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL cont_turn1: got %b exp 0", wb_cyc); end
        tick;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL cont_idle1: got %b exp 0", wb_cyc); end
        tick;
        n_cmp++; if ({wb_cyc, wb_adr, wb_dat, wb_sel, wb_we} !== {1'b1, 32'h300, 32'h0, 4'hF, 1'b0})
            begin n_err++; $display("FAIL cont_second_i: cyc %b adr %h dat %h sel %h we %b exp 1 300 0 f 0", wb_cyc, wb_adr, wb_dat, wb_sel, wb_we); end
        wb_ack = 1'b1; #1;
        n_cmp++; if ({dbus_ack, ibus_ack} !== 2'b01) begin n_err++; $display("FAIL cont_i_ack: got d%b i%b exp d0 i1", dbus_ack, ibus_ack); end
        tick; wb_ack = 1'b0;
        tick;
        tick;
        n_cmp++; if ({wb_cyc, wb_adr, wb_we} !== {1'b1, 32'h2000, 1'b1}) begin n_err++; $display("FAIL cont_third_d: cyc %b adr %h we %b exp 1 2000 1", wb_cyc, wb_adr, wb_we); end
        wb_ack = 1'b1;
        tick; wb_ack = 1'b0; ibus_cyc = 1'b0; dbus_cyc = 1'b0;
        tick;
    endtask

    task automatic test_ibus_fetch;
        ibus_adr = 32'h0000_0100; ibus_cyc = 1'b1;
        #1;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL fetch_req_cyc: got %b exp 0", wb_cyc); end
        tick;
        n_cmp++; if ({wb_cyc, wb_adr, wb_we, wb_sel, wb_dat} !== {1'b1, 32'h100, 1'b0, 4'hF, 32'h0})
            begin n_err++; $display("FAIL fetch_grant: cyc %b adr %h we %b sel %h dat %h exp 1 100 0 f 0", wb_cyc, wb_adr, wb_we, wb_sel, wb_dat); end
        tick;
        n_cmp++; if ({wb_cyc, ibus_ack} !== 2'b10) begin n_err++; $display("FAIL fetch_wait: cyc %b ack %b exp 1 0", wb_cyc, ibus_ack); end
        tick;
        wb_ack = 1'b1; wb_rdt = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({ibus_ack, dbus_ack} !== 2'b10) begin n_err++; $display("FAIL fetch_ack: got i%b d%b exp i1 d0", ibus_ack, dbus_ack); end
        n_cmp++; if (ibus_rdt !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_rdt: got %h exp deadbeef", ibus_rdt); end
        tick; wb_ack = 1'b0; ibus_cyc = 1'b0;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL fetch_turn: got %b exp 0", wb_cyc); end
        n_cmp++; if ({wb_adr, wb_sel} !== {32'h100, 4'hF}) begin n_err++; $display("FAIL fetch_hold: adr %h sel %h exp 100 f", wb_adr, wb_sel); end
        tick;
    endtask

    task automatic test_abort;
        dbus_adr = 32'h40; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
        tick;
        n_cmp++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL abort_grant: cyc %b adr %h exp 1 40", wb_cyc, wb_adr); end
        tick;
        dbus_cyc = 1'b0;
        tick;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL abort_drop: got %b exp 0", wb_cyc); end
        wb_ack = 1'b1; #1;
        n_cmp++; if ({dbus_ack, ibus_ack} !== 2'b00) begin n_err++; $display("FAIL abort_late_turn: got d%b i%b exp 00", dbus_ack, ibus_ack); end
        tick;
        n_cmp++; if ({dbus_ack, ibus_ack, wb_cyc} !== 3'b000) begin n_err++; $display("FAIL abort_late_idle: got d%b i%b cyc %b exp 000", dbus_ack, ibus_ack, wb_cyc); end
        wb_ack = 1'b0;
        tick;
    endtask

    task automatic test_ack_and_drop;
        ibus_adr = 32'h500; ibus_cyc = 1'b1;
        tick;
        wb_ack = 1'b1; ibus_cyc = 1'b0; #1;
        n_cmp++; if (ibus_ack !== 1'b1) begin n_err++; $display("FAIL ackdrop_ack: got %b exp 1", ibus_ack); end
        tick; wb_ack = 1'b0;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL ackdrop_turn: got %b exp 0", wb_cyc); end
        tick;
    endtask

    task automatic test_timeout;
        ibus_adr = 32'h600; ibus_cyc = 1'b1;
        tick; tick; tick; tick;
        n_cmp++; if ({wb_cyc, tmo} !== 2'b10) begin n_err++; $display("FAIL tmo_before: cyc %b tmo %b exp 1 0", wb_cyc, tmo); end
        tick;
        n_cmp++; if ({tmo, tmo_src, wb_cyc, ibus_ack} !== 4'b1000) begin n_err++; $display("FAIL tmo_ibus: tmo %b src %b cyc %b ack %b exp 1 0 0 0", tmo, tmo_src, wb_cyc, ibus_ack); end
        ibus_cyc = 1'b0;
        tick;
        tmo_clr = 1'b1;
        tick; tmo_clr = 1'b0;
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b exp 0", tmo); end
        dbus_adr = 32'h700; dbus_cyc = 1'b1;
        tick; tick; tick; tick;
        tmo_clr = 1'b1;
        tick; tmo_clr = 1'b0; dbus_cyc = 1'b0;
        n_cmp++; if ({tmo, tmo_src, wb_cyc} !== 3'b110) begin n_err++; $display("FAIL tmo_dbus_setwins: tmo %b src %b cyc %b exp 1 1 0", tmo, tmo_src, wb_cyc); end
        tick;
    endtask

    task automatic test_async_reset;
        dbus_adr = 32'h2000; dbus_cyc = 1'b1;
        tick;
        n_cmp++; if ({wb_cyc, tmo} !== 2'b11) begin n_err++; $display("FAIL arst_pre: cyc %b tmo %b exp 1 1", wb_cyc, tmo); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({wb_cyc, tmo, wb_adr} !== {1'b0, 1'b0, 32'h0}) begin n_err++; $display("FAIL arst_now: cyc %b tmo %b adr %h exp 0 0 0", wb_cyc, tmo, wb_adr); end
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (wb_cyc !== 1'b0) begin n_err++; $display("FAIL arst_idle: got %b exp 0", wb_cyc); end
        tick;
        n_cmp++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h2000}) begin n_err++; $display("FAIL arst_regrant: cyc %b adr %h exp 1 2000", wb_cyc, wb_adr); end
        dbus_cyc = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_contention;
        test_ibus_fetch;
        test_abort;
        test_ack_and_drop;
        test_timeout;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
